latent_collector: RTL and testbench
===================================

# latent_collector

Downstream consumer of the encoder `toplevel` datapath. It captures the 16-bit `result` each time a `done` pulse completes and pairs the mu pass (`op_mode`=0) with the following var pass (`op_mode`=1). Each pair is summed into one latent word z = mu + var, which is queued in a first-word-fall-through FIFO and presented on a valid/ready stream to the decoder side. It also tags frame boundaries and flags sequencing and overflow faults.

## Interface
- `DEPTH`, 64: FIFO entries; power of two, minimum 2.
- `NUM_LATENT`, 42: latents per frame; must be 1..65535.
- `W`, 16: data width of `result` and z.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; one clock, asynchronous assert, active-low.
- `flush`  in  1  synchronous clear; same effect as reset, excluding the asynchronous assert.
- `result`  in  W  two's-complement datapath output.
- `done`  in  1  datapath completion strobe.
- `op_mode`  in  1  pass type of the current run: 0 = mu, 1 = var.
- `m_data`  out  W  latent z.
- `m_last`  out  1  high with the last latent of a frame.
- `m_valid`  out  1  stream valid.
- `m_ready`  in  1  stream ready.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `frame_done`  out  1  one-cycle pulse when the NUM_LATENT-th latent is pushed.
- `seq_err`  out  1  sticky sequencing fault.
- `ovf_err`  out  1  sticky overflow fault.

## Operation
- Capture event: `done_q`=1 and `done`=0, where `done_q` is `done` registered. `result` and `op_mode` are sampled in that same cycle.
- FSM states: WAIT_MU (reset state) and WAIT_VAR.
  - WAIT_MU, capture with op_mode=0: store mu_reg, go to WAIT_VAR.
  - WAIT_VAR, capture with op_mode=1: z = mu_reg + result, push z, go to WAIT_MU.
  - Capture with the wrong op_mode in either state: set `seq_err`, discard the sample, keep the current state (mu_reg unchanged).
- Arithmetic: W-bit two's-complement add. The default wraps modulo 2^W, e.g. 0x7FFF + 0x0001 = 0x8000.
- Frame counter `idx` runs 0..NUM_LATENT-1 and advances on every accepted push.
  - The push at idx = NUM_LATENT-1 stores last=1, pulses `frame_done`, and wraps idx to 0.
- FIFO stores {last, z}.
  - Push while full and no pop in the same cycle: drop the entry, set `ovf_err`. idx does not advance and `frame_done` does not pulse.
  - Push while full with a pop in the same cycle: accepted.
  - Pop when `m_valid` && `m_ready`.
  - Simultaneous push and pop: `level` is unchanged.
- Reset or `flush` clears the FIFO, both error flags, idx, mu_reg and done_q, and returns the FSM to WAIT_MU.
  - A capture in the same cycle as `flush` is ignored.
  - Reset mid-pair: the pending mu is lost.

## Timing
- Reset values: `m_data`=0, `m_last`=0, `m_valid`=0, `level`=0, `frame_done`=0, `seq_err`=0, `ovf_err`=0.
- Capture-to-output latency:
  - The z register and FIFO write update at the clock edge ending the capture cycle.
  - `m_valid` is high in the cycle after that edge when the FIFO was empty (FWFT).
  - `m_data` and `m_last` are valid whenever `m_valid`=1.
- `frame_done` is asserted in the cycle following the accepted push, for exactly one cycle.
- `m_data` and `m_last` must hold stable while `m_valid`=1 and `m_ready`=0.
- Throughput: one capture per cycle is tolerated. The datapath spaces captures by ≥ 9 cycles.
- Error flags rise in the cycle after the faulting capture and clear only on reset or `flush`.

## Configuration
- `LATENT_SAT_EN` defined: the add saturates to 0x7FFF / 0x8000 on signed overflow, e.g. 0x7FFF + 0x0001 = 0x7FFF and 0x8000 + 0xFFFF = 0x8000.
- `LATENT_SAT_EN` undefined: wrapping add as described under Operation.

## Structure
- Package `latent_pkg` holds:
  - the FSM state typedef {WAIT_MU, WAIT_VAR};
  - the W default;
  - a constant function for the saturating add.
- Sub-module `latent_fifo` is a parameterised FWFT FIFO (DEPTH, data width W+1) with `level`, full and empty outputs.
- `latent_collector` contains the edge detector, FSM, adder, idx counter and flags.

## Test plan
- Pair: mu pass result=0x0010, var pass result=0xFFF8, `m_ready`=1 → one beat `m_data`=0x0008, `m_last`=0, `m_valid` high in the cycle after the capture edge.
- Frame: 42 mu/var pairs → 42 beats, `m_last`=1 only on beat 42, one `frame_done` pulse; pair 43 restarts with idx=0.
- Overflow: `m_ready`=0, DEPTH+1 pairs → `level`=DEPTH, `ovf_err`=1, and the first DEPTH z values drain in order.
- Sequencing: two consecutive mu captures → `seq_err`=1; first mu retained, so a var capture of 0x0001 after mu=0x0002 yields z=0x0003.
- Arithmetic: mu=0x7FFF, var=0x0001 → z=0x8000 without `LATENT_SAT_EN`, 0x7FFF with it.
- Reset and backpressure:
  - assert `rst_n`=0 between a mu and var capture → all outputs return to reset values, and the next var capture sets `seq_err`;
  - `m_ready` toggling each cycle → `m_data` is held stable while stalled.

Source files
------------

// File: rtl/latent_pkg.sv
// Shared types and helpers for the latent collector: FSM states, default width,
// and the signed saturating add used when LATENT_SAT_EN is defined.
package latent_pkg;

  localparam int LATENT_W = 16;

  typedef enum logic {WAIT_MU = 1'b0, WAIT_VAR = 1'b1} state_t;

  // Operands arrive sign-extended to 32 bits; result is clamped to the signed w-bit range (w <= 31).
  function automatic logic signed [31:0] sat_add(logic signed [31:0] a,
                                                 logic signed [31:0] b,
                                                 int w);
    logic signed [32:0] s;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    s  = 33'(a) + 33'(b);
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (w - 1));
    if (s > hi)      return 32'(hi);
    else if (s < lo) return 32'(lo);
    else             return 32'(s);
  endfunction

endpackage

// File: rtl/latent_collector_if.sv
// Latent output stream (valid/ready) from the collector to the decoder side.
interface latent_collector_if import latent_pkg::*; #(parameter int W = LATENT_W);
  logic [W-1:0] m_data;
  logic         m_last;
  logic         m_valid;
  logic         m_ready;

  modport master (output m_data, output m_last, output m_valid, input m_ready);
  modport slave  (input m_data, input m_last, input m_valid, output m_ready);
endinterface

// File: rtl/latent_fifo.sv
// First-word-fall-through FIFO; head entry is visible on dout while not empty,
// and dout reads as zero when empty.
module latent_fifo #(
  parameter int DEPTH = 64,
  parameter int DW    = 17,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (count == '0);
  assign full    = (count == LW'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign level   = count;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/latent_collector.sv
// Pairs mu/var datapath results into latent words z = mu + var and streams them
// with frame tagging. Define LATENT_SAT_EN for a saturating add instead of wrapping.
module latent_collector import latent_pkg::*; #(
  parameter int DEPTH      = 64,
  parameter int NUM_LATENT = 42,
  parameter int W          = LATENT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic signed [W-1:0]     result,
  input  logic                    done,
  input  logic                    op_mode,
  latent_collector_if.master      m_if,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    frame_done,
  output logic                    seq_err,
  output logic                    ovf_err
);
  state_t              state;
  logic                done_q;
  logic signed [W-1:0] mu_reg;
  logic signed [W-1:0] z;
  logic [15:0]         idx;
  logic                capture;
  logic                take_mu;
  logic                take_var;
  logic                seq_bad;
  logic                pop;
  logic                push_ok;
  logic                drop;
  logic                last_flag;
  logic                fifo_full;
  logic                fifo_empty;
  logic [W:0]          fifo_dout;

  // Capture stage: falling edge of done, gated off during flush
  assign capture  = done_q && !done && !flush;
  assign take_mu  = capture && (state == WAIT_MU)  && !op_mode;
  assign take_var = capture && (state == WAIT_VAR) &&  op_mode;
  assign seq_bad  = capture && !take_mu && !take_var;

`ifdef LATENT_SAT_EN
  assign z = W'(sat_add(32'(mu_reg), 32'(result), W));
`else
  assign z = mu_reg + result;
`endif

  // Push stage: z enters the FIFO at the edge ending the capture cycle
  assign pop       = m_if.m_valid && m_if.m_ready;
  assign push_ok   = take_var && (!fifo_full || pop);
  assign drop      = take_var && fifo_full && !pop;
  assign last_flag = (idx == 16'(NUM_LATENT - 1));

  latent_fifo #(.DEPTH(DEPTH), .DW(W + 1)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (take_var),
    .din   ({last_flag, z}),
    .pop   (pop),
    .dout  (fifo_dout),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign m_if.m_data  = fifo_dout[W-1:0];
  assign m_if.m_last  = fifo_dout[W];
  assign m_if.m_valid = !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_MU;
      done_q     <= 1'b0;
      mu_reg     <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
      seq_err    <= 1'b0;
      ovf_err    <= 1'b0;
    end else if (flush) begin
      state      <= WAIT_MU;
      done_q     <= 1'b0;
      mu_reg     <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
      seq_err    <= 1'b0;
      ovf_err    <= 1'b0;
    end else begin
      done_q     <= done;
      frame_done <= 1'b0;
      case (state)
        WAIT_MU:  if (take_mu) begin
                    mu_reg <= result;
                    state  <= WAIT_VAR;
                  end
        WAIT_VAR: if (take_var) state <= WAIT_MU;
        default:  state <= WAIT_MU;
      endcase
      if (seq_bad) seq_err <= 1'b1;
      if (drop)    ovf_err <= 1'b1;
      // Dropped entries do not consume a frame slot
      if (push_ok) begin
        if (last_flag) begin
          idx        <= '0;
          frame_done <= 1'b1;
        end else begin
          idx <= idx + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_latent_collector.sv
// Scoreboard bench for latent_collector; expected beats are queued by the
// stimulus and compared by an independent stream monitor.
module tb_latent_collector;
  localparam int DEPTH      = 64;
  localparam int NUM_LATENT = 42;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [15:0] result;
  logic        done;
  logic        op_mode;
  logic [$clog2(DEPTH):0] level;
  logic        frame_done;
  logic        seq_err;
  logic        ovf_err;

  latent_collector_if #(.W(16)) s_if ();

  latent_collector #(.DEPTH(DEPTH), .NUM_LATENT(NUM_LATENT), .W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .result     (result),
    .done       (done),
    .op_mode    (op_mode),
    .m_if       (s_if),
    .level      (level),
    .frame_done (frame_done),
    .seq_err    (seq_err),
    .ovf_err    (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_beats  = 0;
  int          fd_cycles = 0;
  int          m_idx    = 0;
  bit          toggle_en = 1'b0;
  logic [16:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame counter: only accepted pushes call this.
  task automatic push_exp(input logic [15:0] z);
    exp_q.push_back({(m_idx == NUM_LATENT - 1), z});
    m_idx = (m_idx == NUM_LATENT - 1) ? 0 : m_idx + 1;
  endtask

  // One datapath run; returns 1 time unit after the capture edge.
  task automatic pass(input bit mode, input logic [15:0] v);
    @(posedge clk); #1 done = 1'b1; op_mode = mode; result = v;
    @(posedge clk); #1 done = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_flush();
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    exp_q.delete();
    m_idx = 0;
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (exp_q.size() == 0 && !s_if.m_valid) break;
      @(posedge clk); #1;
    end
    check("drain_queue", exp_q.size(), 0);
    check("drain_level", level, 0);
  endtask

  // Monitor: at the falling edge the handshake for the next rising edge is settled.
  logic [16:0] prev_beat;
  bit          prev_stall = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (frame_done) fd_cycles++;
      if (prev_stall) check("hold_stable", {s_if.m_last, s_if.m_data}, prev_beat);
      if (s_if.m_valid && s_if.m_ready) begin
        n_beats++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got %h, expected no beat at %0t",
                   {s_if.m_last, s_if.m_data}, $time);
        end else begin
          check("beat", {s_if.m_last, s_if.m_data}, exp_q.pop_front());
        end
      end
      prev_stall = s_if.m_valid && !s_if.m_ready;
      prev_beat  = {s_if.m_last, s_if.m_data};
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (toggle_en) s_if.m_ready = ~s_if.m_ready;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int beats0;
    rst_n = 1'b0; flush = 1'b0; result = '0; done = 1'b0; op_mode = 1'b0;
    s_if.m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_data", s_if.m_data, 0);
    check("rst_m_last", s_if.m_last, 0);
    check("rst_m_valid", s_if.m_valid, 0);
    check("rst_level", level, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_seq_err", seq_err, 0);
    check("rst_ovf_err", ovf_err, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single pair: 0x0010 + 0xFFF8 = 0x0008
    s_if.m_ready = 1'b1;
    pass(1'b0, 16'h0010);
    check("pair_no_valid_after_mu", s_if.m_valid, 0);
    push_exp(16'h0008);
    pass(1'b1, 16'hFFF8);
    check("pair_valid_latency", s_if.m_valid, 1);
    wait_drain(20);

    // Full frame: z = 4*i, last only on the 42nd beat, then restart
    do_flush();
    fd_cycles = 0;
    beats0 = n_beats;
    for (int i = 0; i < NUM_LATENT; i++) begin
      pass(1'b0, 16'(i));
      push_exp(16'(4 * i));
      pass(1'b1, 16'(3 * i));
    end
    wait_drain(20);
    check("frame_beats", n_beats - beats0, NUM_LATENT);
    check("frame_done_cycles", fd_cycles, 1);
    pass(1'b0, 16'h0100);
    push_exp(16'h0101);
    pass(1'b1, 16'h0001);
    wait_drain(20);
    check("frame_restart_no_pulse", fd_cycles, 1);

    // Overflow: DEPTH+1 pairs with the sink stalled
    do_flush();
    s_if.m_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      pass(1'b0, 16'(i));
      push_exp(16'(i + 16'h0200));
      pass(1'b1, 16'h0200);
    end
    check("ovf_level_full", level, DEPTH);
    check("ovf_err_before", ovf_err, 0);
    pass(1'b0, 16'h1111);
    pass(1'b1, 16'h2222);
    check("ovf_level_after", level, DEPTH);
    check("ovf_err_after", ovf_err, 1);
    s_if.m_ready = 1'b1;
    wait_drain(200);
    check("ovf_err_sticky", ovf_err, 1);
    do_flush();
    check("flush_clears_ovf", ovf_err, 0);

    // Sequencing: second mu is rejected and the first mu is kept
    check("seq_err_clear", seq_err, 0);
    pass(1'b0, 16'h0002);
    pass(1'b0, 16'h0005);
    check("seq_err_set", seq_err, 1);
    push_exp(16'h0003);
    pass(1'b1, 16'h0001);
    wait_drain(20);

    // Arithmetic corner cases
`ifdef LATENT_SAT_EN
    push_exp(16'h7FFF);
`else
    push_exp(16'h8000);
`endif
    pass(1'b0, 16'h7FFF);
    pass(1'b1, 16'h0001);
`ifdef LATENT_SAT_EN
    push_exp(16'h8000);
`else
    push_exp(16'h7FFF);
`endif
    pass(1'b0, 16'h8000);
    pass(1'b1, 16'hFFFF);
    wait_drain(20);

    // Reset between mu and var loses the pending mu
    pass(1'b0, 16'h1234);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_m_valid", s_if.m_valid, 0);
    check("midrst_m_data", s_if.m_data, 0);
    check("midrst_level", level, 0);
    check("midrst_seq_err", seq_err, 0);
    check("midrst_frame_done", frame_done, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    exp_q.delete();
    m_idx = 0;
    pass(1'b1, 16'h0001);
    check("midrst_var_seq_err", seq_err, 1);
    check("midrst_var_no_push", level, 0);

    // Backpressure: queue four beats, then drain with ready toggling
    s_if.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pass(1'b0, 16'(16'h0A00 + i));
      push_exp(16'(16'h0A00 + 2 * i + 16'h0010));
      pass(1'b1, 16'(i + 16'h0010));
    end
    check("bp_level", level, 4);
    toggle_en = 1'b1;
    wait_drain(100);
    toggle_en = 1'b0;
    s_if.m_ready = 1'b1;

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
